// File: rtl/vga_pixel_out.sv
// Pixel output stage: glyph shifter, RGBI colour mapping, sync/blank delay line and blink phase.
// Optional build macro CURSOR_EN adds a solid blinking block cursor on the latched cursor cell.
module vga_pixel_out #(
    parameter int SYNC_DLY  = 2,
    parameter int BLINK_BIT = 4
) (
    input  logic       pclk,
    input  logic       rst_n,
    input  logic       shload_n,
    input  logic [7:0] pix_data,
    input  logic [7:0] attr,
    input  logic       cursor_hit,
    input  logic       blank_in,
    input  logic       hsync_in,
    input  logic       vsync_in,
    output logic [3:0] rgbi,
    output logic       hsync,
    output logic       vsync,
    output logic       blank
);

    logic [7:0]          shift_q, shift_d;
    logic [7:0]          attr_q, attr_d;
    logic [BLINK_BIT:0]  cnt_q, cnt_d;
    logic                vs_prev_q;
    logic [SYNC_DLY-1:0] blank_dly_q, hs_dly_q, vs_dly_q;
    logic [3:0]          rgbi_q, rgbi_d;
    logic                blink_ph;
    logic [3:0]          bg_ext, fg_eff;
    logic                pix_on;

`ifdef CURSOR_EN
    logic cur_q, cur_d;

    always_comb begin
        cur_d = cur_q;
        if (!shload_n) begin
            cur_d = cursor_hit;
        end
    end

    always_ff @(posedge pclk or negedge rst_n) begin
        if (!rst_n) begin
            cur_q <= 1'b0;
        end else begin
            cur_q <= cur_d;
        end
    end
`else
    logic unused_cursor_hit;
    assign unused_cursor_hit = cursor_hit;
`endif

    // A load wins over the shift, so a held-low strobe keeps presenting pixel 0.
    always_comb begin
        shift_d = {shift_q[6:0], 1'b0};
        attr_d  = attr_q;
        if (!shload_n) begin
            shift_d = pix_data;
            attr_d  = attr;
        end
    end

    always_comb begin
        cnt_d = cnt_q;
        if (vsync_in && !vs_prev_q) begin
            cnt_d = cnt_q + {{BLINK_BIT{1'b0}}, 1'b1};
        end
    end

    always_comb begin
        blink_ph = cnt_q[BLINK_BIT];
        bg_ext   = {1'b0, attr_q[6:4]};
        fg_eff   = (attr_q[7] && blink_ph) ? bg_ext : attr_q[3:0];
        pix_on   = shift_q[7];
`ifdef CURSOR_EN
        if (cur_q && cnt_q[BLINK_BIT-1]) begin
            pix_on = 1'b1;
        end
`endif
        rgbi_d = blank_dly_q[SYNC_DLY-1] ? 4'h0 : (pix_on ? fg_eff : bg_ext);
    end

    always_ff @(posedge pclk or negedge rst_n) begin
        if (!rst_n) begin
            shift_q   <= 8'h00;
            attr_q    <= 8'h00;
            cnt_q     <= '0;
            vs_prev_q <= 1'b0;
            rgbi_q    <= 4'h0;
        end else begin
            shift_q   <= shift_d;
            attr_q    <= attr_d;
            cnt_q     <= cnt_d;
            vs_prev_q <= vsync_in;
            rgbi_q    <= rgbi_d;
        end
    end

    // Blank resets high so the DAC stays dark until real timing has propagated through.
    always_ff @(posedge pclk or negedge rst_n) begin
        if (!rst_n) begin
            blank_dly_q <= '1;
            hs_dly_q    <= '0;
            vs_dly_q    <= '0;
        end else begin
            blank_dly_q[0] <= blank_in;
            hs_dly_q[0]    <= hsync_in;
            vs_dly_q[0]    <= vsync_in;
            for (int i = 1; i < SYNC_DLY; i++) begin
                blank_dly_q[i] <= blank_dly_q[i-1];
                hs_dly_q[i]    <= hs_dly_q[i-1];
                vs_dly_q[i]    <= vs_dly_q[i-1];
            end
        end
    end

    assign rgbi  = rgbi_q;
    assign blank = blank_dly_q[SYNC_DLY-1];
    assign hsync = hs_dly_q[SYNC_DLY-1];
    assign vsync = vs_dly_q[SYNC_DLY-1];

endmodule

// File: tb/tb_vga_pixel_out.sv
// Self-checking bench for vga_pixel_out: directed scenarios plus random traffic against a cell-level model.
// Cursor scenario is compiled only when CURSOR_EN is defined.
module tb_vga_pixel_out;

    localparam int SYNC_DLY  = 2;
    localparam int BLINK_BIT = 4;

    logic       pclk;
    logic       rst_n;
    logic       shload_n;
    logic [7:0] pix_data;
    logic [7:0] attr;
    logic       cursor_hit;
    logic       blank_in;
    logic       hsync_in;
    logic       vsync_in;
    logic [3:0] rgbi;
    logic       hsync;
    logic       vsync;
    logic       blank;

    int errors = 0;
    int checks = 0;

    vga_pixel_out #(.SYNC_DLY(SYNC_DLY), .BLINK_BIT(BLINK_BIT)) dut (
        .pclk(pclk), .rst_n(rst_n), .shload_n(shload_n), .pix_data(pix_data),
        .attr(attr), .cursor_hit(cursor_hit), .blank_in(blank_in),
        .hsync_in(hsync_in), .vsync_in(vsync_in), .rgbi(rgbi),
        .hsync(hsync), .vsync(vsync), .blank(blank)
    );

    initial pclk = 1'b0;
    always #5 pclk = ~pclk;

    // Reference model: tracks the current cell and how many pixels of it have been emitted.
    logic [7:0] mGlyph, mAttr;
    logic       mCur;
    int         mIdx;
    int         mCnt;
    logic       mPrevVs;
    logic [3:0] mRgbi, mFg, mBg;
    logic       mPix, mBlink;
    logic       mB [SYNC_DLY];
    logic       mH [SYNC_DLY];
    logic       mV [SYNC_DLY];

    always @(posedge pclk or negedge rst_n) begin
        if (!rst_n) begin
            mGlyph  = 8'h00;
            mAttr   = 8'h00;
            mCur    = 1'b0;
            mIdx    = 8;
            mCnt    = 0;
            mPrevVs = 1'b0;
            mRgbi   = 4'h0;
            for (int i = 0; i < SYNC_DLY; i++) begin
                mB[i] = 1'b1;
                mH[i] = 1'b0;
                mV[i] = 1'b0;
            end
        end else begin
            mPix   = (mIdx < 8) ? mGlyph[7-mIdx] : 1'b0;
            mBlink = ((mCnt >> BLINK_BIT) % 2) == 1;
            mBg    = {1'b0, mAttr[6:4]};
            mFg    = (mAttr[7] && mBlink) ? mBg : mAttr[3:0];
`ifdef CURSOR_EN
            if (mCur && (((mCnt >> (BLINK_BIT-1)) % 2) == 1)) mPix = 1'b1;
`endif
            mRgbi = mB[SYNC_DLY-1] ? 4'h0 : (mPix ? mFg : mBg);
            if (!shload_n) begin
                mGlyph = pix_data;
                mAttr  = attr;
                mCur   = cursor_hit;
                mIdx   = 0;
            end else if (mIdx < 8) begin
                mIdx = mIdx + 1;
            end
            if (vsync_in && !mPrevVs) mCnt = (mCnt + 1) % (1 << (BLINK_BIT+1));
            mPrevVs = vsync_in;
            for (int i = SYNC_DLY-1; i > 0; i--) begin
                mB[i] = mB[i-1];
                mH[i] = mH[i-1];
                mV[i] = mV[i-1];
            end
            mB[0] = blank_in;
            mH[0] = hsync_in;
            mV[0] = vsync_in;
        end
    end

    task automatic tick();
        @(posedge pclk);
        #1;
    endtask

    task automatic quiet();
        shload_n   = 1'b1;
        pix_data   = 8'h00;
        attr       = 8'h00;
        cursor_hit = 1'b0;
        blank_in   = 1'b1;
        hsync_in   = 1'b0;
        vsync_in   = 1'b0;
    endtask

    task automatic applyReset();
        rst_n = 1'b0;
        quiet();
        tick();
        tick();
        rst_n = 1'b1;
        tick();
    endtask

    task automatic pulseVsync(input int n);
        for (int i = 0; i < n; i++) begin
            vsync_in = 1'b1;
            tick();
            vsync_in = 1'b0;
            tick();
        end
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        for (int i = 0; i < 4; i++) begin
            shload_n = 1'($urandom); pix_data = 8'($urandom); attr = 8'($urandom);
            cursor_hit = 1'($urandom); blank_in = 1'($urandom);
            hsync_in = 1'($urandom); vsync_in = 1'($urandom);
            tick();
            checks++;
            if (rgbi !== 4'h0 || hsync !== 1'b0 || vsync !== 1'b0 || blank !== 1'b1) begin
                errors++;
                $display("[TB] FAIL reset_hold: rgbi=%h hsync=%b vsync=%b blank=%b want 0 0 0 1", rgbi, hsync, vsync, blank);
            end
        end
        quiet();
        rst_n = 1'b1;
        tick();
        checks++;
        if (rgbi !== 4'h0 || blank !== 1'b1 || hsync !== 1'b0) begin
            errors++;
            $display("[TB] FAIL reset_release: rgbi=%h blank=%b hsync=%b want 0 1 0", rgbi, blank, hsync);
        end
        blank_in = 1'b0;
        repeat (SYNC_DLY + 1) tick();
        shload_n = 1'b0; pix_data = 8'hFF; attr = 8'h0F;
        tick();
        shload_n = 1'b1;
        tick();
        tick();
        checks++;
        if (rgbi !== 4'hF) begin
            errors++;
            $display("[TB] FAIL midcell_before_reset: rgbi=%h want f", rgbi);
        end
        #2 rst_n = 1'b0;
        #1;
        checks++;
        if (rgbi !== 4'h0 || blank !== 1'b1) begin
            errors++;
            $display("[TB] FAIL midcell_async_reset: rgbi=%h blank=%b want 0 1", rgbi, blank);
        end
        quiet();
        tick();
        rst_n = 1'b1;
        tick();
        checks++;
        if (rgbi !== 4'h0) begin
            errors++;
            $display("[TB] FAIL after_midcell_reset: rgbi=%h want 0", rgbi);
        end
    endtask

    task automatic test_single_cell();
        logic [3:0] want [9];
        want = '{4'hE, 4'h1, 4'hE, 4'h1, 4'h1, 4'hE, 4'h1, 4'hE, 4'h1};
        blank_in = 1'b0;
        repeat (SYNC_DLY + 1) tick();
        shload_n = 1'b0; pix_data = 8'hA5; attr = 8'h1E;
        tick();
        shload_n = 1'b1;
        for (int k = 0; k < 9; k++) begin
            pix_data = 8'($urandom); attr = 8'($urandom);
            tick();
            checks++;
            if (rgbi !== want[k] || rgbi !== mRgbi) begin
                errors++;
                $display("[TB] FAIL single_cell px%0d: rgbi=%h want %h (model %h)", k, rgbi, want[k], mRgbi);
            end
        end
    endtask

    task automatic test_blank_sync();
        int first;
        int width;
        blank_in = 1'b1;
        repeat (SYNC_DLY + 1) tick();
        shload_n = 1'b0; pix_data = 8'hFF; attr = 8'h0F;
        tick();
        shload_n = 1'b1;
        for (int k = 0; k < 8; k++) begin
            tick();
            checks++;
            if (rgbi !== 4'h0 || blank !== 1'b1) begin
                errors++;
                $display("[TB] FAIL blank_gate px%0d: rgbi=%h blank=%b want 0 1", k, rgbi, blank);
            end
        end
        first = -1;
        width = 0;
        hsync_in = 1'b1;
        for (int c = 1; c <= 96 + SYNC_DLY + 4; c++) begin
            tick();
            if (c == 96) hsync_in = 1'b0;
            if (hsync === 1'b1) begin
                if (first < 0) first = c;
                width++;
            end
            checks++;
            if (hsync !== mH[SYNC_DLY-1]) begin
                errors++;
                $display("[TB] FAIL hsync_track c%0d: hsync=%b want %b", c, hsync, mH[SYNC_DLY-1]);
            end
        end
        checks++;
        if (first !== SYNC_DLY || width !== 96) begin
            errors++;
            $display("[TB] FAIL hsync_pulse: start=%0d width=%0d want start=%0d width=96", first, width, SYNC_DLY);
        end
    endtask

    task automatic test_back_to_back();
        logic [3:0] want [16];
        want = '{4'h7, 4'h7, 4'h7, 4'h7, 4'h0, 4'h0, 4'h0, 4'h0,
                 4'h0, 4'h0, 4'h0, 4'h0, 4'h7, 4'h7, 4'h7, 4'h7};
        blank_in = 1'b0;
        repeat (SYNC_DLY + 1) tick();
        for (int e = 0; e <= 16; e++) begin
            shload_n = 1'b1;
            if (e == 0) begin shload_n = 1'b0; pix_data = 8'hF0; attr = 8'h07; end
            if (e == 8) begin shload_n = 1'b0; pix_data = 8'h0F; attr = 8'h07; end
            tick();
            if (e >= 1) begin
                checks++;
                if (rgbi !== want[e-1] || rgbi !== mRgbi) begin
                    errors++;
                    $display("[TB] FAIL back_to_back e%0d: rgbi=%h want %h (model %h)", e, rgbi, want[e-1], mRgbi);
                end
            end
        end
        shload_n = 1'b0; pix_data = 8'h80; attr = 8'h07;
        for (int e = 0; e < 5; e++) begin
            if (e == 3) shload_n = 1'b1;
            tick();
            if (e >= 1) begin
                checks++;
                if (rgbi !== ((e <= 3) ? 4'h7 : 4'h0)) begin
                    errors++;
                    $display("[TB] FAIL held_load e%0d: rgbi=%h want %h", e, rgbi, (e <= 3) ? 4'h7 : 4'h0);
                end
            end
        end
    endtask

    task automatic test_blink();
        logic [7:0] attrs [3];
        logic [3:0] want [3];
        attrs = '{8'h9C, 8'h1C, 8'h9C};
        want  = '{4'h1, 4'hC, 4'hC};
        blank_in = 1'b0;
        pulseVsync(16);
        for (int s = 0; s < 3; s++) begin
            if (s == 2) pulseVsync(16);
            shload_n = 1'b0; pix_data = 8'hFF; attr = attrs[s];
            tick();
            shload_n = 1'b1;
            for (int k = 0; k < 8; k++) begin
                tick();
                checks++;
                if (rgbi !== want[s] || rgbi !== mRgbi) begin
                    errors++;
                    $display("[TB] FAIL blink s%0d px%0d: rgbi=%h want %h (model %h)", s, k, rgbi, want[s], mRgbi);
                end
            end
        end
    endtask

    task automatic test_random();
        for (int c = 0; c < 600; c++) begin
            shload_n   = ($urandom_range(0, 7) != 0);
            pix_data   = 8'($urandom);
            attr       = 8'($urandom);
            cursor_hit = 1'($urandom);
            blank_in   = ($urandom_range(0, 5) == 0);
            hsync_in   = 1'($urandom);
            vsync_in   = 1'($urandom);
            tick();
            checks++;
            if (rgbi !== mRgbi || hsync !== mH[SYNC_DLY-1] || vsync !== mV[SYNC_DLY-1] || blank !== mB[SYNC_DLY-1]) begin
                errors++;
                $display("[TB] FAIL random c%0d: rgbi=%h hs=%b vs=%b bl=%b want %h %b %b %b", c, rgbi, hsync, vsync, blank,
                         mRgbi, mH[SYNC_DLY-1], mV[SYNC_DLY-1], mB[SYNC_DLY-1]);
            end
        end
    endtask

`ifdef CURSOR_EN
    task automatic test_cursor();
        logic [3:0] want [2];
        want = '{4'h2, 4'h0};
        applyReset();
        blank_in = 1'b0;
        for (int s = 0; s < 2; s++) begin
            pulseVsync(8);
            shload_n = 1'b0; pix_data = 8'h00; attr = 8'h02; cursor_hit = 1'b1;
            tick();
            shload_n = 1'b1; cursor_hit = 1'b0;
            for (int k = 0; k < 8; k++) begin
                tick();
                checks++;
                if (rgbi !== want[s] || rgbi !== mRgbi) begin
                    errors++;
                    $display("[TB] FAIL cursor s%0d px%0d: rgbi=%h want %h (model %h)", s, k, rgbi, want[s], mRgbi);
                end
            end
        end
    endtask
`endif

    initial begin
        rst_n = 1'b0;
        quiet();
        test_reset();
        test_single_cell();
        test_blank_sync();
        test_back_to_back();
        test_blink();
        test_random();
`ifdef CURSOR_EN
        test_cursor();
`endif
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
